// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and stage-register control outputs shared between
// the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mc_start;
  logic              mc_done;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              idex_stall;
  logic              idex_flush;
  logic              exmem_flush;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
    output ex_branch_taken, mc_start, mc_done,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
    input  ex_branch_taken, mc_start, mc_done,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch
// flushes, multi-cycle EX freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  pipeline_hazard_ctrl_if.slave hz,
  output logic                 mc_timeout_err,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  localparam int TCNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MC_TIMEOUT - 1);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt, tcnt_nxt;
  logic              err_set;

  logic [REG_AW-1:0] rs1, rs2, rd;
  logic              load_use;

  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign rs1 = hz.id_rs1;
  assign rs2 = hz.id_rs2;
  assign rd  = hz.ex_rd;

  assign load_use = hz.ex_mem_read && (rd != '0) &&
                    ((rd == rs1) || (hz.id_uses_rs2 && (rd == rs2)));

  always_comb begin
    state_nxt   = state;
    tcnt_nxt    = tcnt;
    err_set     = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (!Rst) begin
      unique case (state)
        RUN: begin
          if (hz.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
          end else if (hz.mc_start && !hz.mc_done) begin
            state_nxt = MC_WAIT;
            tcnt_nxt  = '0;
          end
        end
        MC_WAIT: begin
          // A completing op releases the front end in the same cycle.
          if (hz.mc_done) begin
            state_nxt = RUN;
          end else begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
            if (tcnt == TCNT_LAST) begin
              err_set   = 1'b1;
              state_nxt = RUN;
            end else begin
              tcnt_nxt = tcnt + TCNT_W'(1);
            end
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state          <= RUN;
      tcnt           <= '0;
      mc_timeout_err <= 1'b0;
      stall_count    <= '0;
      flush_count    <= '0;
    end else begin
      state          <= state_nxt;
      tcnt           <= tcnt_nxt;
      mc_timeout_err <= mc_timeout_err | err_set;
      stall_count    <= sat_inc(stall_count, pc_stall);
      flush_count    <= sat_inc(flush_count, ifid_flush);
    end
  end

  assign hz.pc_stall    = pc_stall;
  assign hz.ifid_stall  = ifid_stall;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_stall  = idex_stall;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with small counter width and
// timeout so saturation and abort paths are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW     = 5;
  localparam int CNT_W      = 3;
  localparam int MC_TIMEOUT = 4;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush}
  localparam logic [5:0] O_IDLE = 6'b000000;
  localparam logic [5:0] O_LU   = 6'b110010;
  localparam logic [5:0] O_BR   = 6'b001010;
  localparam logic [5:0] O_MC   = 6'b110101;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic             mc_timeout_err;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW)) hz ();

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .hz(hz.slave),
    .mc_timeout_err(mc_timeout_err),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, hz.pc_stall, hz.ifid_stall, hz.ifid_flush,
              hz.idex_stall, hz.idex_flush, hz.exmem_flush}, {26'd0, exp});
  endtask

  task automatic clr();
    hz.id_rs1 = '0;          hz.id_rs2 = '0;
    hz.id_uses_rs2 = 1'b0;   hz.ex_rd = '0;
    hz.ex_mem_read = 1'b0;   hz.ex_branch_taken = 1'b0;
    hz.mc_start = 1'b0;      hz.mc_done = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] r);
    hz.ex_mem_read = 1'b1; hz.ex_rd = r; hz.id_rs1 = r;
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic do_reset();
    step(); clr(); Rst = 1'b1; #1;
    chk_out("rst_pulse_out", O_IDLE);
    step(); Rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    // Reset for two cycles with every input asserted.
    step();
    Rst = 1'b1;
    hz.id_rs1 = '1; hz.id_rs2 = '1; hz.id_uses_rs2 = 1'b1; hz.ex_rd = '1;
    hz.ex_mem_read = 1'b1; hz.ex_branch_taken = 1'b1; hz.mc_start = 1'b1; hz.mc_done = 1'b1;
    #1 chk_out("rst_c0_out", O_IDLE);
    step(); #1 chk_out("rst_c1_out", O_IDLE);
    step(); Rst = 1'b0; clr(); #1;
    chk("rst_stall_cnt", stall_count, 0);
    chk("rst_flush_cnt", flush_count, 0);
    chk("rst_err", mc_timeout_err, 0);
    chk_out("rst_idle_out", O_IDLE);

    // Load-use on rs1.
    step(); set_lu(5); #1 chk_out("lu_rs1_out", O_LU);
    step(); clr(); #1 chk_out("lu_rs1_after", O_IDLE);
    chk("lu_rs1_cnt", stall_count, 1);

    // Load-use on rs2, and rs2 ignored when not read.
    step(); hz.ex_mem_read = 1'b1; hz.ex_rd = 7; hz.id_rs1 = 3; hz.id_rs2 = 7; hz.id_uses_rs2 = 1'b1;
    #1 chk_out("lu_rs2_out", O_LU);
    step(); hz.id_uses_rs2 = 1'b0; #1 chk_out("lu_rs2_unused", O_IDLE);
    step(); clr(); set_lu(0); #1 chk_out("lu_rd0", O_IDLE);
    step(); clr(); hz.ex_rd = 5; hz.id_rs1 = 5; #1 chk_out("lu_noload", O_IDLE);
    step(); clr(); #1 chk("lu_cnt2", stall_count, 2);

    // Branch overrides load-use and mc_start.
    step(); set_lu(5); hz.ex_branch_taken = 1'b1; hz.mc_start = 1'b1;
    #1 chk_out("br_prio_out", O_BR);
    step(); clr(); #1 chk_out("br_after_run", O_IDLE);
    chk("br_flush_cnt", flush_count, 1);
    chk("br_stall_cnt", stall_count, 2);

    // Multi-cycle op: start cycle 0, done cycle 4.
    do_reset();
    step(); hz.mc_start = 1'b1; #1 chk_out("mc_c0", O_IDLE);
    step(); clr(); #1 chk_out("mc_c1", O_MC);
    step(); set_lu(9); hz.ex_branch_taken = 1'b1; #1 chk_out("mc_c2_ignore", O_MC);
    step(); clr(); #1 chk_out("mc_c3", O_MC);
    step(); hz.mc_done = 1'b1; #1 chk_out("mc_c4_done", O_IDLE);
    step(); clr(); #1 chk("mc_stall_cnt", stall_count, 3);
    chk("mc_flush_cnt", flush_count, 0);
    set_lu(4); #1 chk_out("mc_c5_run", O_LU);

    // Start and done together: no wait.
    do_reset();
    step(); hz.mc_start = 1'b1; hz.mc_done = 1'b1; #1 chk_out("mc_same_c0", O_IDLE);
    step(); clr(); #1 chk_out("mc_same_c1", O_IDLE);

    // Timeout: four stall cycles, sticky error, reset clears it.
    do_reset();
    step(); hz.mc_start = 1'b1; #1 chk_out("to_c0", O_IDLE);
    step(); clr(); #1 chk_out("to_c1", O_MC);
    step(); #1 chk_out("to_c2", O_MC);
    step(); #1 chk_out("to_c3", O_MC);
    step(); #1 chk_out("to_c4", O_MC);
    chk("to_err_pre", mc_timeout_err, 0);
    step(); #1 chk_out("to_c5_run", O_IDLE);
    chk("to_err_set", mc_timeout_err, 1);
    chk("to_stall_cnt", stall_count, 4);
    step(); #1 chk("to_err_sticky", mc_timeout_err, 1);
    do_reset();
    #1 chk("to_err_cleared", mc_timeout_err, 0);

    // Reset in the middle of a wait aborts it without an error.
    step(); hz.mc_start = 1'b1;
    step(); clr(); #1 chk_out("abort_wait", O_MC);
    step(); Rst = 1'b1; #1 chk_out("abort_rst_out", O_IDLE);
    step(); Rst = 1'b0; #1 chk_out("abort_idle", O_IDLE);
    chk("abort_err", mc_timeout_err, 0);

    // Counter saturation at 2^CNT_W-1.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(); set_lu(6);
    end
    step(); clr(); #1 chk("sat_stall_cnt", stall_count, 7);
    for (int i = 0; i < 10; i++) begin
      step(); hz.ex_branch_taken = 1'b1;
    end
    step(); clr(); #1 chk("sat_flush_cnt", flush_count, 7);
    chk("sat_stall_hold", stall_count, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
